// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency meter.
// No logic here: state encoding, default sizing and the gate-counter width helper.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } fm_state_t;

  localparam int FM_GATE_CYCLES = 524288;
  localparam int FM_CNT_W       = 20;

  function automatic int fm_gcnt_w(input int gate_cycles);
    return $clog2(gate_cycles);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Latency: an input rise before edge N gives edge_p in the cycle after edge N+2.
// No backpressure: one pulse per 0->1 seen at the synchronizer output.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_p
);

  logic [1:0] sync_q;
  logic       sync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
      sync_d <= 1'b0;
      edge_p <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};
      sync_d <= sync_q[1];
      edge_p <= sync_q[1] & ~sync_d;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an async input over a fixed gate of clk cycles.
// Latency: result and count_valid appear GATE_CYCLES+1 cycles after the window opens.
// No backpressure: count_valid is a one-cycle pulse, results hold until the next window.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = FM_GATE_CYCLES,
  parameter int CNT_W       = FM_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int            GW        = fm_gcnt_w(GATE_CYCLES);
  localparam logic [GW-1:0] GCNT_LAST = GW'(GATE_CYCLES - 1);

  fm_state_t        state, state_nxt;
  logic [GW-1:0]    gcnt;
  logic [CNT_W-1:0] ecnt, ecnt_inc;
  logic             sat, sat_inc;
  logic             edge_p;
  logic             gate_last;

  sync_edge_det u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sig_in),
    .edge_p   (edge_p)
  );

  assign gate_last = (gcnt == GCNT_LAST);

  // Saturating increment: an edge arriving at all-ones holds the count and flags it.
  always_comb begin
    ecnt_inc = ecnt;
    sat_inc  = sat;
    if (edge_p) begin
      if (&ecnt) sat_inc  = 1'b1;
      else       ecnt_inc = ecnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = MEASURE;
      MEASURE: begin
        if (!enable)        state_nxt = IDLE;
        else if (gate_last) state_nxt = DONE;
      end
      DONE:    state_nxt = enable ? MEASURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_valid = (state == DONE);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt     <= '0;
      ecnt     <= '0;
      sat      <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        MEASURE: begin
          if (!enable) begin
            gcnt <= '0;
            ecnt <= '0;
            sat  <= 1'b0;
          end else begin
            gcnt <= gate_last ? '0 : gcnt + GW'(1);
            ecnt <= ecnt_inc;
            sat  <= sat_inc;
            // Result registers change on the edge that enters DONE.
            if (gate_last) begin
              count    <= ecnt_inc;
              overflow <= sat_inc;
            end
          end
        end
        DONE: begin
          // An edge seen during DONE belongs to the following window.
          gcnt <= '0;
          ecnt <= (enable && edge_p) ? CNT_W'(1) : '0;
          sat  <= 1'b0;
        end
        default: begin
          gcnt <= '0;
          ecnt <= '0;
          sat  <= 1'b0;
        end
      endcase
    end
  end

endmodule
